// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480@60Hz raster.
// The renderers import this package for screen bounds.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int CLK_DIV = 2;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_window(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// Raster outputs of the timing generator.
// The generator drives them; renderers and the DAC pins consume them.
interface vga_if;
  import vga_pkg::*;

  coord_t x;
  coord_t y;
  logic   active_pixels;
  logic   vga_hs;
  logic   vga_vs;
  logic   vga_blank_n;
  logic   vga_sync_n;
  logic   vga_clk;
  logic   frame_tick;

  modport master (
    output x, y, active_pixels, vga_hs, vga_vs,
           vga_blank_n, vga_sync_n, vga_clk, frame_tick
  );

  modport slave (
    input x, y, active_pixels, vga_hs, vga_vs,
          vga_blank_n, vga_sync_n, vga_clk, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen_pixel_tick.sv
// Divides the system clock down to the pixel rate.
// pix_en marks the last system clock of each pixel.
// pix_en_next marks the clock just before that one.
// vga_clk is low for the first half of the pixel and high for the second half.
module pixel_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output logic pix_en_next,
  output logic vga_clk
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_q, div_d;
  logic             vga_clk_q, vga_clk_d;

  // Next divider count, plus the pixel clock phase that goes with that count.
  always_comb begin
    div_d     = div_q;
    vga_clk_d = vga_clk_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    vga_clk_d = (div_d >= DIV_HALF);
  end

  // Divider register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      vga_clk_q <= vga_clk_d;
    end
  end

  assign pix_en      = (div_q == DIV_LAST);
  assign pix_en_next = (div_d == DIV_LAST);
  assign vga_clk     = vga_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v scan counters with registered sync/blank decode.
// Every output is a flop, so x/y/active/syncs change on the same clock edge.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int G_CLK_DIV  = CLK_DIV,
  parameter int G_H_ACTIVE = H_ACTIVE,
  parameter int G_H_FP     = H_FP,
  parameter int G_H_SYNC   = H_SYNC,
  parameter int G_H_BP     = H_BP,
  parameter int G_V_ACTIVE = V_ACTIVE,
  parameter int G_V_FP     = V_FP,
  parameter int G_V_SYNC   = V_SYNC,
  parameter int G_V_BP     = V_BP
) (
  input  logic   clk,
  input  logic   rst,
  vga_if.master  vga
);

  localparam int     HT     = G_H_ACTIVE + G_H_FP + G_H_SYNC + G_H_BP;
  localparam int     VT     = G_V_ACTIVE + G_V_FP + G_V_SYNC + G_V_BP;
  localparam int     HS_S   = G_H_ACTIVE + G_H_FP;
  localparam int     HS_E   = HS_S + G_H_SYNC;
  localparam int     VS_S   = G_V_ACTIVE + G_V_FP;
  localparam int     VS_E   = VS_S + G_V_SYNC;
  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);

  logic   pix_en, pix_en_next, vga_clk;
  coord_t h_q, h_d, v_q, v_d;
  logic   active_q, active_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   tick_q, tick_d;

  pixel_tick #(.CLK_DIV(G_CLK_DIV)) u_pixel_tick (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .pix_en_next (pix_en_next),
    .vga_clk     (vga_clk)
  );

  // Advance the scan position on each pixel and decode the outputs from the new
  // position, so the registered decode lines up with the registered counters.
  // frame_tick covers the final system clock of the last pixel of the frame.
  always_comb begin
    h_d      = h_q;
    v_d      = v_q;
    active_d = active_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + coord_t'(1);
        end
      end else begin
        h_d = h_q + coord_t'(1);
      end
      active_d = in_window(h_d, 0, G_H_ACTIVE) && in_window(v_d, 0, G_V_ACTIVE);
      hs_d     = !in_window(h_d, HS_S, HS_E);
      vs_d     = !in_window(v_d, VS_S, VS_E);
    end
    tick_d = pix_en_next && (h_d == H_LAST) && (v_d == V_LAST);
  end

  // Counter and output registers; reset drops any sync pulse or tick in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q      <= '0;
      v_q      <= '0;
      active_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      active_q <= active_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      tick_q   <= tick_d;
    end
  end

  assign vga.x             = h_q;
  assign vga.y             = v_q;
  assign vga.active_pixels = active_q;
  assign vga.vga_blank_n   = active_q;
  assign vga.vga_hs        = hs_q;
  assign vga.vga_vs        = vs_q;
  assign vga.vga_sync_n    = 1'b0;
  assign vga.vga_clk       = vga_clk;
  assign vga.frame_tick    = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// Instance A uses the full 640x480 timing for reset and line-level vectors.
// Instance B uses a tiny 16x12 raster with CLK_DIV=4, so that whole frames, vsync,
// frame_tick spacing and mid-frame reset finish in a few thousand clocks.
module tb_vga_timing_gen;

  typedef struct {
    int cyc;
    int x;
    int y;
    int act;
    int hs;
    int vs;
    int vclk;
    int tick;
  } vec_t;

  localparam int NVEC  = 13;
  localparam int B_FRM = 16 * 12 * 4;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   total;
  int   bad;
  vec_t vecs[NVEC];

  vga_if if_a();
  vga_if if_b();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (if_a)
  );

  vga_timing_gen #(
    .G_CLK_DIV  (4),
    .G_H_ACTIVE (8),
    .G_H_FP     (2),
    .G_H_SYNC   (3),
    .G_H_BP     (3),
    .G_V_ACTIVE (6),
    .G_V_FP     (2),
    .G_V_SYNC   (2),
    .G_V_BP     (2)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (if_b)
  );

  // 10-time-unit system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ra, input logic rb, input int n);
    rst_a = ra;
    rst_b = rb;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkVector(input vec_t v);
    string tag;
    tag = $sformatf("a_k%0d", v.cyc);
    checkOutput({tag, "_x"},     int'(if_a.x), v.x);
    checkOutput({tag, "_y"},     int'(if_a.y), v.y);
    checkOutput({tag, "_act"},   int'(if_a.active_pixels), v.act);
    checkOutput({tag, "_blank"}, int'(if_a.vga_blank_n), v.act);
    checkOutput({tag, "_hs"},    int'(if_a.vga_hs), v.hs);
    checkOutput({tag, "_vs"},    int'(if_a.vga_vs), v.vs);
    checkOutput({tag, "_vclk"},  int'(if_a.vga_clk), v.vclk);
    checkOutput({tag, "_tick"},  int'(if_a.frame_tick), v.tick);
    checkOutput({tag, "_sync"},  int'(if_a.vga_sync_n), 0);
  endtask

  initial begin
    int vi;
    int hs_low;
    int first_hs_x;
    int x_changes;
    int prev_x;
    int tick_cnt;
    int act_cnt;
    int hs_b_low;
    int vs_b_low;
    int vs_first_x, vs_first_y, vs_last_x, vs_last_y;
    int viol;
    int exp_act;
    bit found;
    int first_tick_k;
    int tick_k[3];

    total = 0;
    bad   = 0;

    // k = clock edges since reset release; cycle, x, y, act, hs, vs, vclk, tick
    vecs[0]  = '{0,    0,   0, 0, 1, 1, 0, 0};
    vecs[1]  = '{1,    0,   0, 0, 1, 1, 1, 0};
    vecs[2]  = '{2,    1,   0, 1, 1, 1, 0, 0};
    vecs[3]  = '{3,    1,   0, 1, 1, 1, 1, 0};
    vecs[4]  = '{1279, 639, 0, 1, 1, 1, 1, 0};
    vecs[5]  = '{1280, 640, 0, 0, 1, 1, 0, 0};
    vecs[6]  = '{1311, 655, 0, 0, 1, 1, 1, 0};
    vecs[7]  = '{1312, 656, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{1503, 751, 0, 0, 0, 1, 1, 0};
    vecs[9]  = '{1504, 752, 0, 0, 1, 1, 0, 0};
    vecs[10] = '{1599, 799, 0, 0, 1, 1, 1, 0};
    vecs[11] = '{1600, 0,   1, 1, 1, 1, 0, 0};
    vecs[12] = '{1602, 1,   1, 1, 1, 1, 0, 0};

    // ---- Instance A: reset hold, then one full line plus a little ----
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 5);
    checkVector(vecs[0]);
    vi         = 1;
    hs_low     = 0;
    first_hs_x = -1;
    x_changes  = 0;
    prev_x     = int'(if_a.x);
    for (int k = 1; k <= 1602; k++) begin
      applyStimulus(1'b0, 1'b1, 1);
      if (vi < NVEC && vecs[vi].cyc == k) begin
        checkVector(vecs[vi]);
        vi++;
      end
      if (k <= 1600 && if_a.vga_hs == 1'b0) begin
        if (first_hs_x < 0) first_hs_x = int'(if_a.x);
        hs_low++;
      end
      if (int'(if_a.x) != prev_x) x_changes++;
      prev_x = int'(if_a.x);
    end
    checkOutput("a_vec_count", vi, NVEC);
    checkOutput("a_hs_low_clk", hs_low, 192);
    checkOutput("a_hs_first_x", first_hs_x, 656);
    checkOutput("a_x_changes", x_changes, 801);

    // ---- Instance B: three frames on the small raster ----
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("b_rst_x", int'(if_b.x), 0);
    checkOutput("b_rst_hs", int'(if_b.vga_hs), 1);
    tick_cnt   = 0;
    act_cnt    = 0;
    hs_b_low   = 0;
    vs_b_low   = 0;
    vs_first_x = -1;
    vs_first_y = -1;
    vs_last_x  = -1;
    vs_last_y  = -1;
    viol       = 0;
    tick_k[0]  = 767;
    tick_k[1]  = 767 + B_FRM;
    tick_k[2]  = 767 + 2 * B_FRM;
    for (int k = 1; k <= 2400; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      if (if_b.frame_tick == 1'b1) begin
        if (tick_cnt < 3) begin
          checkOutput($sformatf("b_tick%0d_clk", tick_cnt), k, tick_k[tick_cnt]);
          checkOutput($sformatf("b_tick%0d_x", tick_cnt), int'(if_b.x), 15);
          checkOutput($sformatf("b_tick%0d_y", tick_cnt), int'(if_b.y), 11);
        end
        tick_cnt++;
      end
      exp_act = (k >= 4 && if_b.x < 10'd8 && if_b.y < 10'd6) ? 1 : 0;
      if (int'(if_b.active_pixels) != exp_act) viol++;
      if (k >= B_FRM && k < 2 * B_FRM) begin
        if (if_b.active_pixels == 1'b1) act_cnt++;
        if (if_b.vga_hs == 1'b0) hs_b_low++;
        if (if_b.vga_vs == 1'b0) begin
          if (vs_first_x < 0) begin
            vs_first_x = int'(if_b.x);
            vs_first_y = int'(if_b.y);
          end
          vs_last_x = int'(if_b.x);
          vs_last_y = int'(if_b.y);
          vs_b_low++;
        end
      end
    end
    checkOutput("b_tick_pulses", tick_cnt, 3);
    checkOutput("b_active_clk", act_cnt, 192);
    checkOutput("b_active_decode_errs", viol, 0);
    checkOutput("b_hs_low_clk", hs_b_low, 144);
    checkOutput("b_vs_low_clk", vs_b_low, 128);
    checkOutput("b_vs_first_x", vs_first_x, 0);
    checkOutput("b_vs_first_y", vs_first_y, 8);
    checkOutput("b_vs_last_x", vs_last_x, 15);
    checkOutput("b_vs_last_y", vs_last_y, 9);

    // ---- Instance B: reset inside hsync and vsync ----
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      if (if_b.x == 10'd11 && if_b.y == 10'd9) found = 1'b1;
    end
    checkOutput("b_reach_mid", int'(found), 1);
    checkOutput("b_mid_hs", int'(if_b.vga_hs), 0);
    checkOutput("b_mid_vs", int'(if_b.vga_vs), 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("b_mrst_x", int'(if_b.x), 0);
    checkOutput("b_mrst_y", int'(if_b.y), 0);
    checkOutput("b_mrst_hs", int'(if_b.vga_hs), 1);
    checkOutput("b_mrst_vs", int'(if_b.vga_vs), 1);
    checkOutput("b_mrst_act", int'(if_b.active_pixels), 0);
    checkOutput("b_mrst_vclk", int'(if_b.vga_clk), 0);
    checkOutput("b_mrst_tick", int'(if_b.frame_tick), 0);
    first_tick_k = -1;
    for (int k = 1; k <= 1500 && first_tick_k < 0; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      if (if_b.frame_tick == 1'b1) first_tick_k = k;
    end
    checkOutput("b_tick_after_mrst_clk", first_tick_k, 767);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
